// File: rtl/mdio_phy_responder.sv
`timescale 1ns/1ps
// Clause 22 MDIO management responder: oversamples MDC/MDIO on clk, decodes frames
// addressed to PHY_ADDR and bridges them onto a 32 x 16-bit register-file port.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        reg_we,
  output logic [15:0] reg_wdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int            PW      = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic                   mdc_d, mdc_s, mdio_s, mdc_rise, mdc_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_d     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old value.
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
      mdc_d     <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign mdc_s    = mdc_sync[SYNC_STAGES-1];
  assign mdio_s   = mdio_sync[SYNC_STAGES-1];
  assign mdc_rise = mdc_s & ~mdc_d;
  assign mdc_fall = ~mdc_s & mdc_d;

  state_t        state, state_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [PW-1:0] pre_cnt, pre_cnt_n;
  logic [15:0]   shreg, shreg_n, shift_in;
  logic          op_rd, op_rd_n, match, match_n, rd_pend;
  logic          mdio_o_n, mdio_oe_n, reg_re_n, reg_we_n, busy_n, frame_err_n;
  logic [4:0]    reg_addr_n;
  logic [15:0]   reg_wdata_n;

  assign shift_in = {shreg[14:0], mdio_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      pre_cnt   <= '0;
      shreg     <= '0;
      op_rd     <= 1'b0;
      match     <= 1'b0;
      rd_pend   <= 1'b0;
      mdio_o    <= 1'b0;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      pre_cnt   <= pre_cnt_n;
      shreg     <= shreg_n;
      op_rd     <= op_rd_n;
      match     <= match_n;
      rd_pend   <= reg_re;
      mdio_o    <= mdio_o_n;
      mdio_oe   <= mdio_oe_n;
      reg_addr  <= reg_addr_n;
      reg_re    <= reg_re_n;
      reg_we    <= reg_we_n;
      reg_wdata <= reg_wdata_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    pre_cnt_n   = pre_cnt;
    shreg_n     = shreg;
    op_rd_n     = op_rd;
    match_n     = match;
    mdio_o_n    = mdio_o;
    mdio_oe_n   = mdio_oe;
    reg_addr_n  = reg_addr;
    reg_re_n    = 1'b0;
    reg_we_n    = 1'b0;
    reg_wdata_n = reg_wdata;
    busy_n      = busy;
    frame_err_n = 1'b0;

    // Read data arrives the clk after the strobe; load it well before TA ends.
    if (rd_pend) shreg_n = reg_rdata;

    if (mdc_rise) begin
      case (state)
        S_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt != PRE_MAX) pre_cnt_n = pre_cnt + PRE_ONE;
          end else begin
            if (pre_cnt == PRE_MAX) begin
              state_n = S_ST2;
              busy_n  = 1'b1;
            end
            pre_cnt_n = '0;
          end
        end
        S_ST2: begin
          bit_cnt_n = '0;
          if (mdio_s) begin
            state_n = S_OP;
          end else begin
            frame_err_n = 1'b1;
            busy_n      = 1'b0;
            state_n     = S_IDLE;
          end
        end
        S_OP: begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            if (shift_in[1:0] == 2'b10 || shift_in[1:0] == 2'b01) begin
              op_rd_n = shift_in[1];
              state_n = S_PHYAD;
            end else begin
              frame_err_n = 1'b1;
              busy_n      = 1'b0;
              state_n     = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n = '0;
            match_n   = (shift_in[4:0] == PHY_ADDR);
            state_n   = S_REGAD;
          end
        end
        S_REGAD: begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_n  = '0;
            reg_addr_n = shift_in[4:0];
            reg_re_n   = op_rd & match;
            state_n    = S_TA;
          end
        end
        S_TA: begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            state_n   = S_DATA;
          end
        end
        S_DATA: begin
          if (!op_rd) begin
            shreg_n   = shift_in;
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              if (match) begin
                reg_wdata_n = shift_in;
                reg_we_n    = 1'b1;
              end
              bit_cnt_n = '0;
              pre_cnt_n = '0;
              busy_n    = 1'b0;
              state_n   = S_IDLE;
            end
          end else if (bit_cnt != 5'd16) begin
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (mdc_fall) begin
      if (state == S_TA && bit_cnt == 5'd1 && op_rd && match) begin
        mdio_oe_n = 1'b1;
        mdio_o_n  = 1'b0;
      end else if (state == S_DATA && op_rd) begin
        if (bit_cnt != 5'd16) begin
          if (match) mdio_o_n = shreg[15];
          shreg_n = {shreg[14:0], 1'b0};
        end else begin
          // A read ends on the falling edge after D0 so the bus is released cleanly.
          mdio_oe_n = 1'b0;
          mdio_o_n  = 1'b0;
          bit_cnt_n = '0;
          pre_cnt_n = '0;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
`timescale 1ns/1ps
// Self-checking bench for mdio_phy_responder: directed frame table, randomized frames
// against a frame-level reference model, and a reset-mid-read sequence.
module tb_mdio_phy_responder;

  localparam int HALF = 6;  // clk cycles per MDC phase

  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] d;
    bit          e_busy;
    int          e_err;
    int          e_re;
    int          e_we;
    logic [15:0] e_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, mdc, m_oe, m_val;
  logic        mdio_bus, mdio_o, mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_re, reg_we, busy, frame_err;
  logic [15:0] reg_rdata, reg_wdata;

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up when nobody drives.
  assign mdio_bus = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

  mdio_phy_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_i(mdio_bus),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .reg_addr(reg_addr), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .busy(busy), .frame_err(frame_err)
  );

  function automatic logic [15:0] init_pat(input logic [4:0] a);
    return (a == 5'd2) ? 16'h0141 : {8'hA0, 3'b000, a};
  endfunction

  // Register file attached to the DUT port; read data valid the clk after reg_re.
  logic [15:0] mem [32];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_pat(5'(i));
      reg_rdata <= '0;
    end else begin
      if (reg_re) reg_rdata <= mem[reg_addr];
      if (reg_we) mem[reg_addr] <= reg_wdata;
    end
  end

  // Event monitor, sampled away from the active edge.
  int re_cnt = 0, we_cnt = 0, err_cnt = 0, busy_cnt = 0, oe_cnt = 0, clash_cnt = 0, both_cnt = 0;
  logic [4:0]  re_addr, we_addr;
  logic [15:0] we_data;
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_re) begin re_cnt++; re_addr = reg_addr; end
      if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; end
      if (frame_err) err_cnt++;
      if (busy) busy_cnt++;
      if (mdio_oe) oe_cnt++;
      if (mdio_oe && m_oe) clash_cnt++;
      if (reg_re && reg_we) both_cnt++;
    end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Frame builder: bit values, master-drive flags, and per-bit samples at rising MDC.
  logic fb [160];
  logic fd [160];
  logic rs [160];
  logic ro [160];
  int   fn, base;

  task automatic push(input logic drv, input logic val);
    fd[fn] = drv; fb[fn] = val; fn++;
  endtask

  task automatic build(input vec_t v);
    fn = 0;
    push(1'b1, 1'b0);
    for (int i = 0; i < v.pre; i++) push(1'b1, 1'b1);
    base = fn - 2;  // so that base+2 indexes the first ST bit
    base = 1 + v.pre;
    for (int i = 1; i >= 0; i--) push(1'b1, v.st[i]);
    for (int i = 1; i >= 0; i--) push(1'b1, v.op[i]);
    for (int i = 4; i >= 0; i--) push(1'b1, v.phy[i]);
    for (int i = 4; i >= 0; i--) push(1'b1, v.ra[i]);
    if (v.op == 2'b10) begin
      for (int i = 0; i < 18; i++) push(1'b0, 1'b1);
    end else begin
      push(1'b1, 1'b1);
      push(1'b1, 1'b0);
      for (int i = 15; i >= 0; i--) push(1'b1, v.d[i]);
    end
  endtask

  task automatic send_bit(input int i);
    repeat (3) @(negedge clk);
    m_oe = fd[i]; m_val = fb[i];
    repeat (HALF - 3) @(negedge clk);
    mdc = 1'b1;
    rs[i] = mdio_bus; ro[i] = mdio_oe;
    repeat (HALF) @(negedge clk);
    mdc = 1'b0;
  endtask

  logic [15:0] model_mem [32];
  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_mem[i] = init_pat(5'(i));
  endtask

  // Frame-level reference: acceptance, errors and strobes follow from the field values alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit acc  = (v.pre >= 32);
    bit ok   = (v.st == 2'b01) && (v.op == 2'b10 || v.op == 2'b01);
    bit hit  = (v.phy == 5'd1);
    r.e_busy = acc;
    r.e_err  = (acc && !ok) ? 1 : 0;
    r.e_re   = (acc && ok && v.op == 2'b10 && hit) ? 1 : 0;
    r.e_we   = (acc && ok && v.op == 2'b01 && hit) ? 1 : 0;
    r.e_rd   = model_mem[v.ra];
    return r;
  endfunction

  task automatic run_and_check(input string tag, input vec_t v);
    int re0 = re_cnt, we0 = we_cnt, er0 = err_cnt, bz0 = busy_cnt, oe0 = oe_cnt, cl0 = clash_cnt, bo0 = both_cnt;
    logic [15:0] rd;
    build(v);
    for (int i = 0; i < fn; i++) send_bit(i);
    repeat (HALF + 2) @(negedge clk);
    check({tag, "_re_count"}, re_cnt - re0, v.e_re);
    check({tag, "_we_count"}, we_cnt - we0, v.e_we);
    check({tag, "_err_count"}, err_cnt - er0, v.e_err);
    check({tag, "_busy_seen"}, (busy_cnt - bz0) != 0, v.e_busy);
    check({tag, "_oe_seen"}, (oe_cnt - oe0) != 0, v.e_re != 0);
    check({tag, "_no_clash_no_dual"}, (clash_cnt - cl0) + (both_cnt - bo0), 0);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_oe_after"}, mdio_oe, 1'b0);
    if (v.e_re != 0) begin
      rd = '0;
      for (int k = 0; k < 16; k++) rd = {rd[14:0], rs[base + 16 + k]};
      check({tag, "_re_addr"}, re_addr, v.ra);
      check({tag, "_ta1_oe"}, ro[base + 14], 1'b0);
      check({tag, "_ta2_bus"}, {ro[base + 15], rs[base + 15]}, 2'b10);
      check({tag, "_rdata"}, rd, v.e_rd);
    end
    if (v.e_we != 0) begin
      check({tag, "_we_addr"}, we_addr, v.ra);
      check({tag, "_wdata"}, we_data, v.d);
      model_mem[v.ra] = v.d;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl [13];
  vec_t rv;

  initial begin
    tbl[0]  = '{32, 2'b01, 2'b01, 5'd1, 5'd4, 16'hBEEF, 1, 0, 0, 1, 16'h0000};
    tbl[1]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 1, 0, 1, 0, 16'h0141};
    tbl[2]  = '{32, 2'b01, 2'b01, 5'd3, 5'd5, 16'h1234, 1, 0, 0, 0, 16'h0000};
    tbl[3]  = '{32, 2'b01, 2'b10, 5'd3, 5'd2, 16'h0000, 1, 0, 0, 0, 16'h0000};
    tbl[4]  = '{32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0000, 1, 0, 1, 0, 16'hBEEF};
    tbl[5]  = '{31, 2'b01, 2'b01, 5'd1, 5'd6, 16'h5555, 0, 0, 0, 0, 16'h0000};
    tbl[6]  = '{32, 2'b01, 2'b01, 5'd1, 5'd6, 16'h5555, 1, 0, 0, 1, 16'h0000};
    tbl[7]  = '{32, 2'b01, 2'b11, 5'd1, 5'd6, 16'h0000, 1, 1, 0, 0, 16'h0000};
    tbl[8]  = '{32, 2'b01, 2'b10, 5'd1, 5'd6, 16'h0000, 1, 0, 1, 0, 16'h5555};
    tbl[9]  = '{32, 2'b01, 2'b00, 5'd1, 5'd7, 16'h0000, 1, 1, 0, 0, 16'h0000};
    tbl[10] = '{32, 2'b00, 2'b01, 5'd1, 5'd7, 16'hABCD, 1, 1, 0, 0, 16'h0000};
    tbl[11] = '{36, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0000, 1, 0, 1, 0, 16'hA005};
    tbl[12] = '{30, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 0, 0, 0, 0, 16'h0000};

    reset = 1'b1; mdc = 1'b0; m_oe = 1'b0; m_val = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {mdio_oe, mdio_o, reg_re, reg_we, busy, frame_err}, 6'b0);
    check("reset_addr_wdata", {reg_addr, reg_wdata}, 21'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) run_and_check($sformatf("dir%0d", i), tbl[i]);

    for (int i = 0; i < 30; i++) begin
      rv.pre = $urandom_range(29, 36);
      rv.st  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      rv.op  = 2'($urandom_range(0, 3));
      rv.phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
      rv.ra  = 5'($urandom_range(0, 31));
      rv.d   = 16'($urandom);
      run_and_check($sformatf("rnd%0d", i), model(rv));
    end

    // Reset asserted while the PHY is driving D8 of a read.
    rv = '{32, 2'b01, 2'b10, 5'd1, 5'd9, 16'h0000, 1, 0, 1, 0, 16'h0000};
    build(rv);
    for (int i = 0; i < base + 16 + 7; i++) send_bit(i);
    repeat (3) @(negedge clk);
    m_oe = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    mdc = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_oe", mdio_oe, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_oe", mdio_oe, 1'b0);
    check("async_reset_outputs", {mdio_o, reg_re, reg_we, busy, frame_err}, 5'b0);
    check("async_reset_addr_wdata", {reg_addr, reg_wdata}, 21'h0);
    mdc = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rv = '{32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 1, 0, 1, 0, 16'h0141};
    run_and_check("post_reset_read", rv);
    rv = '{32, 2'b01, 2'b01, 5'd1, 5'd9, 16'h3C5A, 1, 0, 0, 1, 16'h0000};
    run_and_check("post_reset_write", rv);
    run_and_check("post_reset_readback", model('{32, 2'b01, 2'b10, 5'd1, 5'd9, 16'h0, 0, 0, 0, 0, 16'h0}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
